// File: rtl/freq_div_pkg.sv
// Shared constants and the high-phase clamp rule for the programmable clock divider.
package freq_div_pkg;

  localparam int CW_DEF      = 8;
  localparam int MAX_CH      = 16;
  localparam int MIN_DIV     = 2;
  // High phase must end at least this many cycles before the period wraps.
  localparam int HIGH_MARGIN = 1;

  function automatic int unsigned clamp_high(input int unsigned div, input int unsigned high);
    return (high >= div) ? (div - HIGH_MARGIN) : high;
  endfunction

endpackage

// File: rtl/freq_div_ch.sv
// One divider channel: period counter, active/pending config, registered clock and period-start outputs.
module freq_div_ch
  import freq_div_pkg::*;
#(
  parameter int             CW       = CW_DEF,
  parameter logic [CW-1:0]  RST_DIV  = CW'(4),
  parameter logic [CW-1:0]  RST_HIGH = CW'(2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          wr_i,
  input  logic [CW-1:0] div_i,
  input  logic [CW-1:0] high_i,
  output logic          clk_o,
  output logic          start_o,
  output logic          pend_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] pdiv_q, pdiv_d;
  logic [CW-1:0] phigh_q, phigh_d;
  logic          pend_q, pend_d;
  logic          run_q, run_d;
  logic          clk_q, clk_d;
  logic          start_q, start_d;
  logic          last_cnt;
  logic          boundary;

  always_comb begin
    last_cnt = (cnt_q == (div_q - CW'(1)));
    // No period in flight (idle, stopping, or wrapping): config can land without cutting a pulse.
    boundary = !run_q || !en_i || last_cnt;

    div_d   = div_q;
    high_d  = high_q;
    pdiv_d  = pdiv_q;
    phigh_d = phigh_q;
    pend_d  = pend_q;

    if (boundary) begin
      if (wr_i) begin
        div_d  = div_i;
        high_d = high_i;
      end else if (pend_q) begin
        div_d  = pdiv_q;
        high_d = phigh_q;
      end
      pend_d = 1'b0;
    end else if (wr_i) begin
      pdiv_d  = div_i;
      phigh_d = high_i;
      pend_d  = 1'b1;
    end

    run_d = en_i;
    if (!en_i || !run_q || last_cnt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Outputs are registered from the next count so they line up with cnt in the same cycle.
    clk_d   = en_i && (cnt_d < high_d);
    start_d = en_i && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      high_q  <= RST_HIGH;
      pdiv_q  <= RST_DIV;
      phigh_q <= RST_HIGH;
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
      clk_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      high_q  <= high_d;
      pdiv_q  <= pdiv_d;
      phigh_q <= phigh_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
      clk_q   <= clk_d;
      start_q <= start_d;
    end
  end

  assign clk_o   = clk_q;
  assign start_o = start_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/freq_div_prog.sv
// Multi-channel programmable clock divider: config decode, clamp and error pulse, plus NUM_CH channels.
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CW       = CW_DEF,
  parameter int DEF_DIV  = 4,
  parameter int DEF_HIGH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CW-1:0]     cfg_div,
  input  logic [CW-1:0]     cfg_high,
  output logic [NUM_CH-1:0] clk_div_out,
  output logic [NUM_CH-1:0] period_start,
  output logic [NUM_CH-1:0] cfg_pend,
  output logic              cfg_err
);

  localparam logic [CW-1:0] RST_DIV  = CW'(DEF_DIV);
  localparam logic [CW-1:0] RST_HIGH = CW'(clamp_high(DEF_DIV, DEF_HIGH));
  localparam int            CH_LIM   = (NUM_CH < MAX_CH) ? NUM_CH : MAX_CH;

  logic          accept;
  logic [CW-1:0] high_clamped;
  logic          cfg_err_q, cfg_err_d;

  always_comb begin
    accept       = cfg_wr && (32'(cfg_ch) < 32'(CH_LIM)) && (32'(cfg_div) >= 32'(MIN_DIV));
    high_clamped = CW'(clamp_high(32'(cfg_div), 32'(cfg_high)));
    cfg_err_d    = cfg_wr && !accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    freq_div_ch #(
      .CW       (CW),
      .RST_DIV  (RST_DIV),
      .RST_HIGH (RST_HIGH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en[g]),
      .wr_i    (accept && (cfg_ch == 4'(g))),
      .div_i   (cfg_div),
      .high_i  (high_clamped),
      .clk_o   (clk_div_out[g]),
      .start_o (period_start[g]),
      .pend_o  (cfg_pend[g])
    );
  end

endmodule

// File: tb/tb_freq_div_prog.sv
// Self-checking bench for freq_div_prog: per-scenario tasks with an expected-value queue.
module tb_freq_div_prog;

  localparam int NUM_CH = 4;
  localparam int CW     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              cfg_wr;
  logic [3:0]        cfg_ch;
  logic [CW-1:0]     cfg_div;
  logic [CW-1:0]     cfg_high;
  logic [NUM_CH-1:0] clk_div_out;
  logic [NUM_CH-1:0] period_start;
  logic [NUM_CH-1:0] cfg_pend;
  logic              cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  // Entry layout: {clk_div_out, period_start, cfg_pend, cfg_err} for one channel.
  logic [3:0] exp_q[$];

  freq_div_prog #(.NUM_CH(NUM_CH), .CW(CW), .DEF_DIV(4), .DEF_HIGH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_wr       (cfg_wr),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .cfg_high     (cfg_high),
    .clk_div_out  (clk_div_out),
    .period_start (period_start),
    .cfg_pend     (cfg_pend),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [3:0] ch, input logic [CW-1:0] dv, input logic [CW-1:0] hi);
    cfg_wr   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = dv;
    cfg_high = hi;
  endtask

  function automatic logic [3:0] obs(input int ch);
    return {clk_div_out[ch], period_start[ch], cfg_pend[ch], cfg_err};
  endfunction

  task automatic test_reset;
    logic [3:0] got;
    rst = 1'b1;
    en  = '1;
    drive_write(4'd0, 8'd3, 8'd1);
    tick();
    tick();
    got = {|clk_div_out, |period_start, |cfg_pend, cfg_err};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000", got);
    end
    rst    = 1'b0;
    en     = '0;
    cfg_wr = 1'b0;
    tick();
    got = {|clk_div_out, |period_start, |cfg_pend, cfg_err};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 0000", got);
    end
  endtask

  task automatic test_default;
    logic [3:0] exp, got;
    en = 4'b0001;
    tick();
    for (int i = 0; i < 12; i++) exp_q.push_back({1'((i % 4) < 2), 1'((i % 4) == 0), 2'b00});
    for (int i = 0; i < 12; i++) begin
      exp = exp_q.pop_front();
      got = obs(0);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL default_div4 cyc %0d: got %b want %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_reconfig;
    logic [3:0] exp, got;
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'((i % 8) < 3), 1'((i % 8) == 0), 2'b00});
    for (int i = 0; i < 20; i++) begin
      if (i == 1) drive_write(4'd0, 8'd8, 8'd3);
      if (i == 2) cfg_wr = 1'b0;
      exp = exp_q.pop_front();
      got = obs(0);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reconfig_div8 cyc %0d: got %b want %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_clamp;
    logic [3:0] exp, got;
    drive_write(4'd1, 8'd5, 8'd7);
    tick();
    cfg_wr = 1'b0;
    got = obs(1);
    n_cmp++;
    if (got !== 4'b0000) begin
      n_err++;
      $display("FAIL clamp_disabled_load: got %b want 0000", got);
    end
    en = 4'b0011;
    tick();
    for (int i = 0; i < 10; i++) exp_q.push_back({1'((i % 5) < 4), 1'((i % 5) == 0), 2'b00});
    for (int i = 0; i < 10; i++) begin
      exp = exp_q.pop_front();
      got = obs(1);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL clamp_div5 cyc %0d: got %b want %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_reject;
    logic [3:0] exp, got;
    en = '0;
    tick();
    tick();
    en = 4'b0100;
    tick();
    for (int i = 0; i < 12; i++)
      exp_q.push_back({1'((i % 4) < 2), 1'((i % 4) == 0), 1'b0, 1'((i == 2) || (i == 6))});
    for (int i = 0; i < 12; i++) begin
      if (i == 1) drive_write(4'd2, 8'd1, 8'd0);
      if (i == 5) drive_write(4'(NUM_CH), 8'd6, 8'd2);
      if (i == 2 || i == 6) cfg_wr = 1'b0;
      exp = exp_q.pop_front();
      got = obs(2);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reject_write cyc %0d: got %b want %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_last_wins;
    logic [3:0] exp, got;
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 9; i++) exp_q.push_back({1'((i % 3) == 0), 1'((i % 3) == 0), 2'b00});
    for (int i = 0; i < 13; i++) begin
      if (i == 0) drive_write(4'd2, 8'd6, 8'd2);
      if (i == 1) drive_write(4'd2, 8'd3, 8'd1);
      if (i == 2) cfg_wr = 1'b0;
      exp = exp_q.pop_front();
      got = obs(2);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL last_wins cyc %0d: got %b want %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp, got;
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'((i % 4) < 3), 1'((i % 4) == 0), 2'b00});
    for (int i = 0; i < 11; i++) begin
      if (i == 2) drive_write(4'd2, 8'd4, 8'd3);
      if (i == 3) cfg_wr = 1'b0;
      exp = exp_q.pop_front();
      got = obs(2);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL wrap_write cyc %0d: got %b want %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset;
    logic [3:0]  exp, got;
    logic [12:0] bus;
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b1010);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_write(4'd2, 8'd7, 8'd1);
      if (i == 1) begin
        cfg_wr = 1'b0;
        rst    = 1'b1;
      end
      exp = exp_q.pop_front();
      got = obs(2);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL pre_reset cyc %0d: got %b want %b", i, got, exp);
      end
      tick();
    end
    bus = {clk_div_out, period_start, cfg_pend, cfg_err};
    n_cmp++;
    if (bus !== 13'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %b want 0", bus);
    end
    rst = 1'b0;
    en  = 4'b0101;
    tick();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'((i % 4) < 2), 1'((i % 4) == 0), 2'b00});
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      got = obs(2);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_defaults_ch2 cyc %0d: got %b want %b", i, got, exp);
      end
      got = obs(0);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_defaults_ch0 cyc %0d: got %b want %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_disable;
    logic [3:0] got;
    en = 4'b0000;
    tick();
    got = obs(0);
    n_cmp++;
    if (got !== 4'b0000) begin
      n_err++;
      $display("FAIL disable_ch0: got %b want 0000", got);
    end
    en = 4'b0001;
    tick();
    got = obs(0);
    n_cmp++;
    if (got !== 4'b1100) begin
      n_err++;
      $display("FAIL reenable_ch0: got %b want 1100", got);
    end
    tick();
    got = obs(0);
    n_cmp++;
    if (got !== 4'b1000) begin
      n_err++;
      $display("FAIL reenable_ch0_cnt1: got %b want 1000", got);
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = '0;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_high = '0;
    test_reset();
    test_default();
    test_reconfig();
    test_clamp();
    test_reject();
    test_last_wins();
    test_back_to_back();
    test_mid_reset();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
